// File: rtl/rom_fetch_unit.sv
// Fetch stage in front of the program ROM: PC, registered word, redirect, fault trap.
// Optional fetch/stall counters are built when ROM_FETCH_PERF_EN is defined.
module rom_fetch_unit #(
  parameter int          ADDR_W   = 12,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clock,
  input  logic              nReset,
  output logic [ADDR_W-1:0] RomAddress,
  input  logic [DATA_W-1:0] RomData,
  input  logic              Redirect,
  input  logic [31:0]       RedirectPc,
  input  logic              InstrReady,
  output logic              InstrValid,
  output logic [DATA_W-1:0] Instr,
  output logic [31:0]       InstrPc,
  output logic              Fault,
  output logic [31:0]       FaultPc
`ifdef ROM_FETCH_PERF_EN
  ,
  output logic [31:0]       FetchCount,
  output logic [31:0]       StallCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [31:0]       ipc_q, ipc_d;
  logic              fault_q, fault_d;
  logic [31:0]       fpc_q, fpc_d;

  function automatic logic bad_addr(
    input logic [31:0] a
  );
    bad_addr = (a[1:0] != 2'b00) ||
               ((a >> (ADDR_W + 2)) != 32'd0);
  endfunction

  logic pc_bad;
  logic tgt_bad;
  logic adv;

  assign pc_bad  = bad_addr(pc_q);
  assign tgt_bad = bad_addr(RedirectPc);
  assign adv     = !valid_q || InstrReady;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
        if (Redirect) pc_d = RedirectPc;
      end
      S_RUN: begin
        if (Redirect) begin
          valid_d = 1'b0;
          pc_d    = RedirectPc;
        end else if (pc_bad) begin
          // a pending word either transfers now or is dropped
          valid_d = 1'b0;
          fault_d = 1'b1;
          fpc_d   = pc_q;
          state_d = S_HALT;
        end else if (adv) begin
          instr_d = RomData;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
        if (Redirect) begin
          if (tgt_bad) begin
            fpc_d = RedirectPc;
          end else begin
            fault_d = 1'b0;
            pc_d    = RedirectPc;
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  assign RomAddress = pc_q[ADDR_W+1:2];
  assign InstrValid = valid_q;
  assign Instr      = instr_q;
  assign InstrPc    = ipc_q;
  assign Fault      = fault_q;
  assign FaultPc    = fpc_q;

`ifdef ROM_FETCH_PERF_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] scnt_q, scnt_d;
  logic        live;

  assign live = (state_q != S_HALT);

  always_comb begin
    fcnt_d = fcnt_q;
    scnt_d = scnt_q;
    if (live && valid_q && InstrReady)
      fcnt_d = fcnt_q + 32'd1;
    if (live && valid_q && !InstrReady)
      scnt_d = scnt_q + 32'd1;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign FetchCount = fcnt_q;
  assign StallCount = scnt_q;
`endif

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: directed vector table, reset corner, random vs model.
module tb_rom_fetch_unit;

  localparam int AW = 12;

  logic          Clock;
  logic          nReset;
  logic [AW-1:0] RomAddress;
  logic [31:0]   RomData;
  logic          Redirect;
  logic [31:0]   RedirectPc;
  logic          InstrReady;
  logic          InstrValid;
  logic [31:0]   Instr;
  logic [31:0]   InstrPc;
  logic          Fault;
  logic [31:0]   FaultPc;
`ifdef ROM_FETCH_PERF_EN
  logic [31:0]   FetchCount;
  logic [31:0]   StallCount;
`endif

  int checks;
  int failures;

  rom_fetch_unit #(
    .ADDR_W(AW),
    .DATA_W(32),
    .RESET_PC(32'h0)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .RomAddress(RomAddress),
    .RomData(RomData),
    .Redirect(Redirect),
    .RedirectPc(RedirectPc),
    .InstrReady(InstrReady),
    .InstrValid(InstrValid),
    .Instr(Instr),
    .InstrPc(InstrPc),
    .Fault(Fault),
    .FaultPc(FaultPc)
`ifdef ROM_FETCH_PERF_EN
    ,
    .FetchCount(FetchCount),
    .StallCount(StallCount)
`endif
  );

  // ROM word k holds 0x1000_0000 + k
  assign RomData = 32'h1000_0000 + {20'd0, RomAddress};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Behavioural reference: fetch stream computed from address rules.
  logic [31:0] m_pc, m_instr, m_ipc, m_fpc;
  logic        m_v, m_f, m_halt, m_started;

  function automatic logic in_rom(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    return (x % 4 == 0) && (x < 4 * (64'd1 << AW));
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_fpc = 32'h0;
    m_v = 1'b0; m_f = 1'b0; m_halt = 1'b0; m_started = 1'b0;
  endtask

  task automatic model_step(
    input logic rd, input logic [31:0] rpc, input logic rdy
  );
    if (!m_started) begin
      m_started = 1'b1;
      if (rd) m_pc = rpc;
    end else if (m_halt) begin
      if (rd) begin
        if (in_rom(rpc)) begin
          m_halt = 1'b0; m_f = 1'b0; m_pc = rpc;
        end else begin
          m_fpc = rpc;
        end
      end
    end else if (rd) begin
      m_v = 1'b0; m_pc = rpc;
    end else if (!in_rom(m_pc)) begin
      m_v = 1'b0; m_f = 1'b1; m_fpc = m_pc; m_halt = 1'b1;
    end else if (!m_v || rdy) begin
      m_instr = rom_word(m_pc); m_ipc = m_pc;
      m_v = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick(
    input logic rd, input logic [31:0] rpc, input logic rdy
  );
    Redirect = rd; RedirectPc = rpc; InstrReady = rdy;
    @(posedge Clock);
    model_step(rd, rpc, rdy);
    #1;
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        v;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        f;
    logic [31:0] fpc;
  } vec_t;

  function automatic vec_t mk(
    input logic rd, input logic [31:0] rpc, input logic rdy,
    input logic v, input logic [31:0] instr, input logic [31:0] ipc,
    input logic f, input logic [31:0] fpc
  );
    vec_t t;
    t.rd = rd; t.rpc = rpc; t.rdy = rdy; t.v = v;
    t.instr = instr; t.ipc = ipc; t.f = f; t.fpc = fpc;
    return t;
  endfunction

  vec_t vt[23];

  initial begin
    checks = 0;
    failures = 0;
    vt[0]  = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        32'h0,    1'b0, 32'h0);
    vt[1]  = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0000, 32'h0,   1'b0, 32'h0);
    vt[2]  = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0001, 32'h4,   1'b0, 32'h0);
    vt[3]  = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0002, 32'h8,   1'b0, 32'h0);
    vt[4]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 32'h1000_0002, 32'h8,   1'b0, 32'h0);
    vt[5]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 32'h1000_0002, 32'h8,   1'b0, 32'h0);
    vt[6]  = mk(1'b0, 32'h0,    1'b0, 1'b1, 32'h1000_0002, 32'h8,   1'b0, 32'h0);
    vt[7]  = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0003, 32'hC,   1'b0, 32'h0);
    vt[8]  = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0004, 32'h10,  1'b0, 32'h0);
    vt[9]  = mk(1'b1, 32'h100,  1'b1, 1'b0, 32'h0,        32'h0,    1'b0, 32'h0);
    vt[10] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0040, 32'h100, 1'b0, 32'h0);
    vt[11] = mk(1'b1, 32'h102,  1'b1, 1'b0, 32'h0,        32'h0,    1'b0, 32'h0);
    vt[12] = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        32'h0,    1'b1, 32'h102);
    vt[13] = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        32'h0,    1'b1, 32'h102);
    vt[14] = mk(1'b1, 32'h200,  1'b1, 1'b0, 32'h0,        32'h0,    1'b0, 32'h0);
    vt[15] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0080, 32'h200, 1'b0, 32'h0);
    vt[16] = mk(1'b1, 32'h3FF8, 1'b1, 1'b0, 32'h0,        32'h0,    1'b0, 32'h0);
    vt[17] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0FFE, 32'h3FF8, 1'b0, 32'h0);
    vt[18] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0FFF, 32'h3FFC, 1'b0, 32'h0);
    vt[19] = mk(1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        32'h0,    1'b1, 32'h4000);
    vt[20] = mk(1'b1, 32'h1000_0000, 1'b1, 1'b0, 32'h0,   32'h0,    1'b1, 32'h1000_0000);
    vt[21] = mk(1'b1, 32'h20,   1'b1, 1'b0, 32'h0,        32'h0,    1'b0, 32'h0);
    vt[22] = mk(1'b0, 32'h0,    1'b1, 1'b1, 32'h1000_0008, 32'h20,  1'b0, 32'h0);

    nReset = 1'b0; Redirect = 1'b0; RedirectPc = 32'h0; InstrReady = 1'b0;
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    #1;
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_ipc", InstrPc, 32'd0);
    chk("rst_fault", {31'd0, Fault}, 32'd0);
    chk("rst_fpc", FaultPc, 32'd0);
    chk("rst_addr", {20'd0, RomAddress}, 32'd0);
`ifdef ROM_FETCH_PERF_EN
    chk("rst_fcnt", FetchCount, 32'd0);
`endif

    for (int i = 0; i < 23; i++) begin
      tick(vt[i].rd, vt[i].rpc, vt[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'd0, InstrValid}, {31'd0, vt[i].v});
      chk($sformatf("vec%0d_fault", i), {31'd0, Fault}, {31'd0, vt[i].f});
      if (vt[i].v) begin
        chk($sformatf("vec%0d_instr", i), Instr, vt[i].instr);
        chk($sformatf("vec%0d_ipc", i), InstrPc, vt[i].ipc);
      end
      if (vt[i].f)
        chk($sformatf("vec%0d_fpc", i), FaultPc, vt[i].fpc);
      if (i >= 4 && i <= 6)
        chk($sformatf("vec%0d_stall_addr", i), {20'd0, RomAddress}, 32'd3);
    end

    // asynchronous reset in the middle of a stream
    nReset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("mid_rst_instr", Instr, 32'd0);
    chk("mid_rst_ipc", InstrPc, 32'd0);
    chk("mid_rst_fault", {31'd0, Fault}, 32'd0);
    chk("mid_rst_addr", {20'd0, RomAddress}, 32'd0);
`ifdef ROM_FETCH_PERF_EN
    chk("mid_rst_fcnt", FetchCount, 32'd0);
`endif
    @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    tick(1'b0, 32'h0, 1'b1);
    chk("restart_idle", {31'd0, InstrValid}, 32'd0);
    tick(1'b0, 32'h0, 1'b1);
    chk("restart_valid", {31'd0, InstrValid}, 32'd1);
    chk("restart_ipc", InstrPc, 32'h0);
    chk("restart_instr", Instr, 32'h1000_0000);

    for (int c = 0; c < 400; c++) begin
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      int          k;
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      k   = $urandom_range(0, 9);
      if (k == 0)
        rpc = {18'd0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
      else if (k == 1)
        rpc = $urandom | 32'h0001_0000;
      else if (k == 2)
        rpc = 32'h3FF0 + 32'(4 * $urandom_range(0, 3));
      else
        rpc = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      tick(rd, rpc, rdy);
      chk("rnd_valid", {31'd0, InstrValid}, {31'd0, m_v});
      chk("rnd_fault", {31'd0, Fault}, {31'd0, m_f});
      if (m_f) chk("rnd_fpc", FaultPc, m_fpc);
      if (m_v) begin
        chk("rnd_instr", Instr, m_instr);
        chk("rnd_ipc", InstrPc, m_ipc);
      end
      if (!m_halt)
        chk("rnd_addr", {20'd0, RomAddress}, {20'd0, m_pc[AW+1:2]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
Name: rom_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the program ROM (12-bit word address, 32-bit data, combinational read).
- Holds the PC, drives the ROM word address, registers the returned word, and presents instruction and PC to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute.
- Traps misaligned and out-of-range fetches.

Parameters:
- ADDR_W, 12: ROM word-address width; ROM spans 4*2^ADDR_W bytes.
- DATA_W, 32: instruction width.
- RESET_PC, 32'h0000_0000: PC loaded on reset; must be word-aligned.

Ports:
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous, active-low reset.
- RomAddress  out  ADDR_W  word address to ROM = Pc[ADDR_W+1:2].
- RomData  in  DATA_W  ROM read data, combinational from RomAddress.
- Redirect  in  1  load RedirectPc this cycle, flushing the output register.
- RedirectPc  in  32  redirect target byte address.
- InstrReady  in  1  decode accepts Instr this cycle.
- InstrValid  out  1  Instr/InstrPc hold a valid fetched word.
- Instr  out  DATA_W  fetched instruction.
- InstrPc  out  32  byte address of Instr.
- Fault  out  1  fetch halted on a bad address.
- FaultPc  out  32  offending address.

Behaviour:
- Reset (async, nReset=0): Pc=RESET_PC; InstrValid=0; Instr=0; InstrPc=0; Fault=0; FaultPc=0; state=IDLE.
- States:
  - IDLE: one cycle after reset release, no fetch; goes to RUN.
  - RUN: normal fetch.
  - HALT: faulted.
- RomAddress is always Pc[ADDR_W+1:2], combinational from the Pc register.
- Advance condition in RUN: adv = !InstrValid || InstrReady.
- On adv, with no Redirect and Pc in range:
  - Instr<=RomData; InstrPc<=Pc; InstrValid<=1; Pc<=Pc+4.
  - Latency: Pc to InstrValid is 1 cycle; back-to-back issue at 1 instruction per cycle when InstrReady is held high.
- Stall: when InstrValid=1 and InstrReady=0, Instr, InstrPc, InstrValid and Pc all hold.
- Redirect has priority over adv and over stall:
  - InstrValid<=0 next cycle (wrong-path word dropped, even if InstrReady=1 that cycle).
  - Pc<=RedirectPc.
  - First fetch from the new target happens the following cycle, so the redirect bubble is 1 cycle.
- Range/alignment check, applied to the Pc about to be fetched:
  - Fault condition: Pc[1:0]!=0 or Pc[31:ADDR_W+2]!=0.
  - On a fault in RUN: no fetch; InstrValid<=0 (a pending valid word is first transferred if InstrReady=1 that cycle, otherwise dropped); Fault<=1; FaultPc<=Pc; state=HALT.
- Wrap-around: Pc+4 past the last ROM word (e.g. 0x3FFC+4=0x4000 with ADDR_W=12) is not wrapped; the next fetch attempt faults with FaultPc=0x4000.
- HALT:
  - Fault holds at 1 and InstrValid=0; InstrReady is ignored.
  - A Redirect to a valid address clears Fault, loads Pc and returns to RUN.
  - A Redirect to an invalid address stays in HALT and updates FaultPc.
- Redirect in IDLE: Pc is loaded; the state still goes to RUN.
- Reset mid-operation: all registers clear asynchronously regardless of state; no partial transfer is presented.
- Arithmetic: Pc+4 is 32-bit modulo; overflow past 0xFFFF_FFFC is caught by the range check.

Optional Feature:
- Macro: ROM_FETCH_PERF_EN.
- Defined:
  - Adds outputs FetchCount[31:0] and StallCount[31:0].
  - FetchCount increments on each InstrValid&&InstrReady transfer.
  - StallCount increments on each cycle with InstrValid&&!InstrReady.
  - Both reset to 0, wrap modulo 2^32, and freeze in HALT.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, InstrReady=1, ROM word k = 0x1000_0000+k -> InstrValid rises on the 2nd edge after release; Instr/InstrPc sequence 0x1000_0000/0x0, 0x1000_0001/0x4, 0x1000_0002/0x8 on consecutive cycles.
- InstrReady=0 for 3 cycles while InstrValid=1 at InstrPc=0x8 -> Instr, InstrPc and RomAddress=3 hold; InstrPc=0x8 then resumes, followed by 0xC.
- Redirect=1, RedirectPc=0x100 while InstrValid=1 at 0x10 -> next cycle InstrValid=0; following cycle Instr=ROM[0x40], InstrPc=0x100.
- Redirect to 0x102 -> Fault=1, FaultPc=0x102, InstrValid stays 0; then Redirect to 0x200 -> Fault=0, Instr=ROM[0x80].
- Redirect to 0x3FF8 with InstrReady=1 -> words at 0x3FF8 and 0x3FFC delivered, then Fault=1, FaultPc=0x4000.
- nReset pulsed low mid-stream at InstrPc=0x20 -> all outputs 0 immediately; fetch restarts at RESET_PC; with ROM_FETCH_PERF_EN, FetchCount returns to 0.
